// File: rtl/mem_arb.sv
// Two-master arbiter for the shared data-memory port.
// Round-robin between m0 (load/store unit) and m1 (DMA/debug loader), with an
// optional bounded lock so the previous owner can run back-to-back bursts.
// Request/write path is combinational; read data returns one cycle after grant.

// Per-master read-return register: captures crossbar read data at the edge
// that ends a read grant and flags it valid for exactly one cycle.
module mem_arb_rport #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  take,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    // rvalid pulses after a read grant; rdata keeps the last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= take;
            if (take) rdata <= din;
        end
    end

endmodule

module mem_arb #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_lock,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_data,
    input  logic                    m0_wren,
    input  logic [DATA_WIDTH/8-1:0] m0_mask,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_lock,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_data,
    input  logic                    m1_wren,
    input  logic [DATA_WIDTH/8-1:0] m1_mask,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [DATA_WIDTH/8-1:0] o_mask,
    output logic                    o_wren,
    input  logic [DATA_WIDTH-1:0]   i_data
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);

    // Both masters packed side by side so the mux and read ports index by master id.
    logic [1:0]                 req, lock, wren, gnt;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] data;
    logic [1:0][MW-1:0]         mask;
    logic [1:0]                 rvalid;
    logic [1:0][DATA_WIDTH-1:0] rdata;

    assign req  = {m1_req,  m0_req};
    assign lock = {m1_lock, m0_lock};
    assign wren = {m1_wren, m0_wren};
    assign addr = {m1_addr, m0_addr};
    assign data = {m1_data, m0_data};
    assign mask = {m1_mask, m0_mask};

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];

    // last = previous owner (reset to m1 so m0 wins the first contention);
    // hold_cnt = consecutive grants to last, saturating at MAX_HOLD.
    logic          last;
    logic [HW-1:0] hold_cnt;

    logic any;   // some master is granted this cycle
    logic sel;   // which master is granted when any is set
    logic keep;  // previous owner may keep the port under contention

    // Grant decision: a lone requester always wins; under contention the
    // previous owner keeps the port only while locked and under its hold budget.
    always_comb begin
        any  = 1'b0;
        sel  = last;
        keep = lock[last] && (hold_cnt < HOLD_SAT);
        case (req)
            2'b01: begin
                any = 1'b1;
                sel = 1'b0;
            end
            2'b10: begin
                any = 1'b1;
                sel = 1'b1;
            end
            2'b11: begin
                any = 1'b1;
                sel = keep ? last : ~last;
            end
            default: ;
        endcase
    end

    assign gnt = any ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Output mux: granted master drives the crossbar, otherwise everything is
    // zero so an idle cycle can never look like a write.
    always_comb begin
        o_addr = '0;
        o_data = '0;
        o_mask = '0;
        o_wren = 1'b0;
        if (any) begin
            o_addr = addr[sel];
            o_data = data[sel];
            o_mask = mask[sel];
            o_wren = wren[sel];
        end
    end

    // Ownership tracking: extend the streak for a repeat owner, restart it on
    // a hand-over, and leave everything alone on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= 1'b1;
            hold_cnt <= '0;
        end else if (any) begin
            if (sel == last) begin
                if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= HW'(1);
            end
            last <= sel;
        end
    end

    // One read-return register per master; only read grants capture data.
    for (genvar i = 0; i < 2; i++) begin : g_rport
        mem_arb_rport #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rport (
            .clk    (clk),
            .rst    (rst),
            .take   (gnt[i] & ~wren[i]),
            .din    (i_data),
            .rvalid (rvalid[i]),
            .rdata  (rdata[i])
        );
    end

endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: small behavioural memory on the crossbar side plus a
// reference model of ownership/streak, read returns and memory contents.
module tb_mem_arb;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int MAX_HOLD = 4;

    logic          clk, rst;
    logic          m0_req, m0_lock, m0_wren, m1_req, m1_lock, m1_wren;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_data, m1_data;
    logic [MW-1:0] m0_mask, m1_mask;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [MW-1:0] o_mask;
    logic          o_wren;
    logic [DW-1:0] i_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_data(m0_data),
        .m0_wren(m0_wren), .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_data(m1_data),
        .m1_wren(m1_wren), .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .o_addr(o_addr), .o_data(o_data), .o_mask(o_mask), .o_wren(o_wren),
        .i_data(i_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Crossbar-side memory: 256 words indexed by the low address byte.
    logic [DW-1:0] mem [256];
    assign i_data = mem[o_addr[7:0]];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h10] <= 32'hDEADBEEF;
        end else if (o_wren) begin
            for (int b = 0; b < MW; b++)
                if (o_mask[b]) mem[o_addr[7:0]][8*b +: 8] <= o_data[8*b +: 8];
        end
    end

    // ---------------- reference model ----------------
    int            m_last;    // previous owner
    int            m_streak;  // unbounded count of consecutive grants to m_last
    bit [1:0]      exp_rv;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] ref_mem [256];

    task automatic model_reset();
        m_last = 1; m_streak = 0; exp_rv = 2'b00;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_mem[8'h10] = 32'hDEADBEEF;
    endtask

    function automatic int exp_grant();
        bit lk;
        if (!m0_req && !m1_req) return -1;
        if (m0_req && !m1_req) return 0;
        if (!m0_req) return 1;
        lk = (m_last == 1) ? m1_lock : m0_lock;
        if (lk && m_streak < MAX_HOLD) return m_last;
        return 1 - m_last;
    endfunction

    function automatic logic [1:0] exp_gnt_bits(int g);
        if (g < 0) return 2'b00;
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // {wren, mask, data, addr} expected on the crossbar side
    function automatic logic [AW+DW+MW:0] exp_obus(int g);
        if (g < 0) return '0;
        if (g == 1) return {m1_wren, m1_mask, m1_data, m1_addr};
        return {m0_wren, m0_mask, m0_data, m0_addr};
    endfunction

    // Advance one clock, applying the spec's effects of the current inputs to the model.
    task automatic step();
        int g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [MW-1:0] k;
        logic w;
        g = exp_grant();
        exp_rv = 2'b00;
        if (g >= 0) begin
            a = (g == 1) ? m1_addr : m0_addr;
            d = (g == 1) ? m1_data : m0_data;
            k = (g == 1) ? m1_mask : m0_mask;
            w = (g == 1) ? m1_wren : m0_wren;
            if (w) begin
                for (int b = 0; b < MW; b++)
                    if (k[b]) ref_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
            end else begin
                exp_rv[g] = 1'b1;
                exp_rd[g] = ref_mem[a[7:0]];
            end
            if (g == m_last) m_streak++;
            else m_streak = 1;
            m_last = g;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_wren = 0; m0_addr = '0; m0_data = '0; m0_mask = '0;
        m1_req = 0; m1_lock = 0; m1_wren = 0; m1_addr = '0; m1_data = '0; m1_mask = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        n_checks++;
        if ({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000", {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt});
        else n_pass++;
        n_checks++;
        if ({m1_rdata, m0_rdata} !== '0)
            $display("FAIL reset_rdata: got %h want 0", {m1_rdata, m0_rdata});
        else n_pass++;
        n_checks++;
        if ({o_wren, o_mask, o_data, o_addr} !== '0)
            $display("FAIL reset_obus: got %h want 0", {o_wren, o_mask, o_data, o_addr});
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 30'h10; m0_wren = 0; m0_mask = 4'hF;
        @(negedge clk);
        n_checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01 || o_addr !== 30'h10 || o_wren !== 1'b0)
            $display("FAIL single_gnt: got gnt=%b addr=%h wren=%b want gnt=01 addr=10 wren=0",
                     {m1_gnt, m0_gnt}, o_addr, o_wren);
        else n_pass++;
        step();
        clear_inputs();
        n_checks++;
        if ({m1_rvalid, m0_rvalid} !== 2'b01 || m0_rdata !== 32'hDEADBEEF)
            $display("FAIL single_rdata: got rv=%b rdata=%h want rv=01 rdata=deadbeef",
                     {m1_rvalid, m0_rvalid}, m0_rdata);
        else n_pass++;
        step();
        n_checks++;
        if ({m1_rvalid, m0_rvalid} !== 2'b00)
            $display("FAIL single_rv_drop: got %b want 00", {m1_rvalid, m0_rvalid});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 0, 1, 0, 1};
        logic [1:0] eg;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            m0_req = 1; m0_lock = 0; m0_wren = 0; m0_addr = 30'(8'h40 + i); m0_mask = 4'hF;
            m1_req = 1; m1_lock = 0; m1_wren = 0; m1_addr = 30'(8'h80 + i); m1_mask = 4'hF;
            @(negedge clk);
            eg = (seq[i] == 1) ? 2'b10 : 2'b01;
            n_checks++;
            if ({m1_gnt, m0_gnt} !== eg || o_addr !== ((seq[i] == 1) ? m1_addr : m0_addr))
                $display("FAIL rr_cycle%0d: got gnt=%b addr=%h want gnt=%b addr=%h", i,
                         {m1_gnt, m0_gnt}, o_addr, eg, (seq[i] == 1) ? m1_addr : m0_addr);
            else n_pass++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_lock_hold();
        int seq [6] = '{1, 1, 1, 1, 0, 1};
        logic [1:0] eg;
        do_reset();
        m0_req = 1; m0_lock = 0; m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            eg = (seq[i] == 1) ? 2'b10 : 2'b01;
            n_checks++;
            if ({m1_gnt, m0_gnt} !== eg)
                $display("FAIL lock_cycle%0d: got %b want %b", i, {m1_gnt, m0_gnt}, eg);
            else n_pass++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        m0_req = 1; m0_wren = 1; m0_addr = 30'h20; m0_data = 32'h12345678; m0_mask = 4'b0011;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1 || o_wren !== 1'b1 || o_mask !== 4'b0011)
            $display("FAIL wr_gnt: got gnt=%b wren=%b mask=%b want 1 1 0011", m0_gnt, o_wren, o_mask);
        else n_pass++;
        step();
        clear_inputs();
        m1_req = 1; m1_wren = 0; m1_addr = 30'h20; m1_mask = 4'hF;
        n_checks++;
        if (m0_rvalid !== 1'b0)
            $display("FAIL wr_no_rvalid: got %b want 0", m0_rvalid);
        else n_pass++;
        step();
        clear_inputs();
        n_checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h00005678)
            $display("FAIL wr_readback: got rv=%b rdata=%h want 1 00005678", m1_rvalid, m1_rdata);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        int seq [3] = '{1, 1, 0};
        logic [1:0] eg;
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 30'h3;
        step();
        step();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m1_gnt, m0_gnt, o_wren, o_mask, o_data, o_addr} !== '0)
                $display("FAIL idle_cycle%0d: got gnt=%b bus=%h want all 0", i,
                         {m1_gnt, m0_gnt}, {o_wren, o_mask, o_data, o_addr});
            else n_pass++;
            step();
        end
        m0_req = 1; m1_req = 1; m1_lock = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            eg = (seq[i] == 1) ? 2'b10 : 2'b01;
            n_checks++;
            if ({m1_gnt, m0_gnt} !== eg)
                $display("FAIL idle_resume%0d: got %b want %b", i, {m1_gnt, m0_gnt}, eg);
            else n_pass++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m0_req  = ($urandom_range(0, 3) != 0);
            m1_req  = ($urandom_range(0, 3) != 0);
            m0_lock = $urandom_range(0, 1) != 0;
            m1_lock = $urandom_range(0, 1) != 0;
            m0_wren = $urandom_range(0, 2) == 0;
            m1_wren = $urandom_range(0, 2) == 0;
            m0_addr = {22'($urandom), 8'($urandom_range(0, 15))};
            m1_addr = {22'($urandom), 8'($urandom_range(0, 15))};
            m0_data = $urandom;
            m1_data = $urandom;
            m0_mask = 4'($urandom);
            m1_mask = 4'($urandom);
            @(negedge clk);
            g = exp_grant();
            n_checks++;
            if ({m1_gnt, m0_gnt} !== exp_gnt_bits(g))
                $display("FAIL rnd_gnt%0d: got %b want %b", i, {m1_gnt, m0_gnt}, exp_gnt_bits(g));
            else n_pass++;
            n_checks++;
            if ({o_wren, o_mask, o_data, o_addr} !== exp_obus(g))
                $display("FAIL rnd_obus%0d: got %h want %h", i, {o_wren, o_mask, o_data, o_addr}, exp_obus(g));
            else n_pass++;
            n_checks++;
            if ({m1_rvalid, m0_rvalid} !== exp_rv)
                $display("FAIL rnd_rvalid%0d: got %b want %b", i, {m1_rvalid, m0_rvalid}, exp_rv);
            else n_pass++;
            n_checks++;
            if ({m1_rdata, m0_rdata} !== {exp_rd[1], exp_rd[0]})
                $display("FAIL rnd_rdata%0d: got %h want %h", i, {m1_rdata, m0_rdata}, {exp_rd[1], exp_rd[0]});
            else n_pass++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        m1_req = 1; m1_wren = 0; m1_addr = 30'h10; m1_mask = 4'hF;
        step();
        clear_inputs();
        n_checks++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF)
            $display("FAIL arst_pre: got rv=%b rdata=%h want 1 deadbeef", m1_rvalid, m1_rdata);
        else n_pass++;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (m1_rvalid !== 1'b0 || m1_rdata !== '0)
            $display("FAIL arst_drop: got rv=%b rdata=%h want 0 0", m1_rvalid, m1_rdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        m0_req = 1; m1_req = 1; m0_addr = 30'h5; m1_addr = 30'h6;
        #1;
        n_checks++;
        if ({m1_gnt, m0_gnt} !== 2'b01)
            $display("FAIL arst_first: got %b want 01", {m1_gnt, m0_gnt});
        else n_pass++;
        step();
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_hold();
        test_write_read();
        test_idle_hold();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-master arbiter that shares the single data-memory port (the crossbar's core-side port) between two requesters: the core's load/store unit (m0) and a second bus master such as a DMA or debug loader (m1).
- Completes at most one transfer per cycle.
- Arbitration is round-robin, with an optional bounded lock that allows back-to-back bursts.
- Writes are forwarded combinationally. Read data is registered and returned one cycle after grant.

Parameters:
- ADDR_WIDTH, 30, word-address width of all address ports
- DATA_WIDTH, 32, data width. The mask width is DATA_WIDTH/8.
- MAX_HOLD, 8, maximum consecutive grants to a locked master while the other master is requesting. Must be at least 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- m0_req  in  1  master 0 transfer request
- m0_lock  in  1  master 0 asks to keep ownership for the next cycle
- m0_addr  in  ADDR_WIDTH  master 0 word address
- m0_data  in  DATA_WIDTH  master 0 write data
- m0_wren  in  1  master 0 write enable (1 = write, 0 = read)
- m0_mask  in  DATA_WIDTH/8  master 0 byte mask
- m0_gnt  out  1  combinational; transfer accepted this cycle
- m0_rvalid  out  1  registered; read data valid
- m0_rdata  out  DATA_WIDTH  registered read data
- m1_*  same set as m0_*, for master 1
- o_addr  out  ADDR_WIDTH  to crossbar
- o_data  out  DATA_WIDTH  to crossbar
- o_mask  out  DATA_WIDTH/8  to crossbar
- o_wren  out  1  to crossbar
- i_data  in  DATA_WIDTH  combinational read data from crossbar

Behaviour:
- Registered state:
  - last: last granted master, 1 bit
  - hold_cnt: consecutive grants to last, width $clog2(MAX_HOLD+1)
  - per-master rvalid and rdata registers
- Reset values (asynchronous, on rst=1):
  - last=1, so m0 wins the first contention
  - hold_cnt=0
  - m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0
  - rvalid drops immediately on reset, including mid-transfer
- Grant decision, combinational and evaluated every cycle in this priority order:
  1. Neither req: no grant.
  2. Exactly one req: grant that master, regardless of lock or hold_cnt.
  3. Both req, the last master has lock=1 and hold_cnt < MAX_HOLD: grant last.
  4. Both req, otherwise: grant !last (round-robin).
- The lock signal is sampled from the master that owned the previous grant, held in last.
- At most one of m0_gnt and m1_gnt is high in any cycle.
- Output mux:
  - When granted, o_addr/o_data/o_mask/o_wren are the granted master's signals.
  - When not granted, all o_* are 0. In particular, o_wren=0 so no spurious writes occur.
- A write is committed by the memory at the rising edge that ends the grant cycle.
- Read path:
  - At the edge ending a grant with wren=0, mX_rdata <= i_data and mX_rvalid <= 1 for the granted master.
  - Otherwise mX_rvalid <= 0 and mX_rdata holds its value.
  - Read latency is one cycle after gnt. There is no backpressure on rvalid.
  - Write grants never raise rvalid.
- Counter update on each grant to master X:
  - If X == last, hold_cnt <= min(hold_cnt+1, MAX_HOLD), saturating.
  - Else hold_cnt <= 1.
  - Then last <= X.
- With no grant, last and hold_cnt are held unchanged.
- Masters may change req, addr or data in any cycle. There is no requirement to hold a request stable until granted; a master simply retries.
- Lock with no contention has no effect on ownership; the counter still saturates.

Test Plan:
- Reset, then m0 reads addr 0x10 (memory holds 0xDEADBEEF) alone → m0_gnt=1 in the same cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF; m1_rvalid=0.
- m0 and m1 both request every cycle with lock=0 for 6 cycles → grants alternate m0, m1, m0, m1, m0, m1; never both high; o_* follow the granted master.
- MAX_HOLD=4, m1 holds lock=1 with both requesting continuously → m1 is granted 4 consecutive cycles, then m0 for 1 cycle, then m1 again.
- m0 writes 0x12345678 mask 4'b0011 to addr 0x20, then m1 reads addr 0x20 (initial 0) → m1_rdata=0x00005678; the write grant produced no rvalid.
- Idle cycles with no req → o_wren=0, o_mask=0, o_addr=0, o_data=0; last and hold_cnt unchanged across 10 idle cycles.
- Assert rst asynchronously mid-cycle while m1_rvalid=1 → m1_rvalid=0 immediately; after release, contention grants m0 first.
